// File: rtl/bitrev_load_ctrl.sv
// rtl/bitrev_load_ctrl.sv - loads a 64-sample frame into RAM in bit-reversed order, then starts the FFT core.
module bitrev_load_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [5:0]        ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_WAIT
    } state_t;

    state_t            state;
    logic [5:0]        idx;
    logic [CNT_W-1:0]  wait_cnt;
    logic              accept;

    assign in_ready = (state == S_LOAD);
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 6'd0;
            wait_cnt  <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= 6'd0;
            ram_wdata <= '0;
            fft_start <= 1'b0;
            frame_cnt <= 8'd0;
            err       <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            fft_start <= 1'b0;

            // Each accepted sample lands in RAM on the following cycle at its bit-reversed slot.
            if (accept) begin
                ram_we    <= 1'b1;
                ram_addr  <= {idx[0], idx[1], idx[2], idx[3], idx[4], idx[5]};
                ram_wdata <= in_data;
                idx       <= idx + 6'd1;
            end

            case (state)
                S_IDLE: begin
                    if (en) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (accept && idx == 6'd63) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    state     <= S_START;
                    fft_start <= 1'b1;
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    // A done pulse on the timeout edge still counts as a completed frame.
                    if (fft_done) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        wait_cnt  <= '0;
                        state     <= en ? S_LOAD : S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err      <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
